// File: rtl/core_lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
// Holds funct3 encodings, the LSU state enum and the alignment check.
package core_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RDATA = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Stores have no unsigned forms, so BU/HU stores count as undefined.
    function automatic logic lsu_misaligned(
        input logic       store,
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic mis;
        case (f3)
            F3_B:    mis = 1'b0;
            F3_BU:   mis = store;
            F3_H:    mis = lo[0];
            F3_HU:   mis = store | lo[0];
            F3_W:    mis = (lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Byte-lane logic for the LSU: store lane replication and byte
// enables, load lane extraction with sign or zero extension.
module core_lsu_align
    import core_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        byte_en_o = 4'b0000;
        wdata_o   = wdata_i;
        case (funct3_i)
            F3_B: begin
                byte_en_o = 4'b0001 << addr_lo_i;
                wdata_o   = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                byte_en_o = 4'b0011 << addr_lo_i;
                wdata_o   = {2{wdata_i[15:0]}};
            end
            F3_W: begin
                byte_en_o = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        rdata_o = rdata_i;
        case (funct3_i)
            F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata_o = {24'h0, shifted[7:0]};
            F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata_o = {16'h0, shifted[15:0]};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// RV32I load/store unit: accepts one op, drives the arbiter's LSU
// read/write ports and returns a single-cycle response pulse.
module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_en,
    input  logic          i_req_valid,
    input  logic          i_req_store,
    input  logic [2:0]    i_req_funct3,
    input  logic [AW-1:0] i_req_addr,
    input  logic [DW-1:0] i_req_wdata,
    output logic          o_req_ready,
    output logic          o_resp_valid,
    output logic [DW-1:0] o_resp_data,
    output logic          o_misaligned,
    output logic          o_lsu_read,
    output logic [AW-1:0] o_r_lsu_addr,
    input  logic [DW-1:0] i_r_lsu_data,
    output logic          o_lsu_write,
    output logic [AW-1:0] o_w_lsu_addr,
    output logic [3:0]    o_w_lsu_byte_en,
    output logic [DW-1:0] o_w_lsu_data,
    input  logic          i_mem_stall
);

    lsu_state_t    state_q, state_d;
    logic          store_q, store_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          mis_q, mis_d;

    logic [3:0]    lane_be;
    logic [DW-1:0] lane_wdata;
    logic [DW-1:0] lane_rdata;
    logic [AW-1:0] word_addr;

    core_lsu_align u_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (i_r_lsu_data),
        .byte_en_o (lane_be),
        .wdata_o   (lane_wdata),
        .rdata_o   (lane_rdata)
    );

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    store_d  = i_req_store;
                    funct3_d = i_req_funct3;
                    addr_d   = i_req_addr;
                    wdata_d  = i_req_wdata;
                    rdata_d  = '0;
                    mis_d    = lsu_misaligned(i_req_store,
                                   i_req_funct3, i_req_addr[1:0]);
                    state_d  = mis_d ? RESP : REQ;
                end
            end
            REQ: begin
                if (!i_mem_stall) begin
                    state_d = store_q ? RESP : RDATA;
                end
            end
            RDATA: begin
                rdata_d = lane_rdata;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset wins over the clock enable; a disabled edge holds everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
        end else if (i_clk_en) begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
        end
    end

    assign word_addr       = {addr_q[AW-1:2], 2'b00};
    assign o_req_ready     = (state_q == IDLE);
    assign o_resp_valid    = (state_q == RESP);
    assign o_resp_data     = o_resp_valid ? rdata_q : '0;
    assign o_misaligned    = o_resp_valid & mis_q;
    assign o_lsu_read      = (state_q == REQ) & ~store_q;
    assign o_lsu_write     = (state_q == REQ) & store_q;
    assign o_r_lsu_addr    = o_lsu_read ? word_addr : '0;
    assign o_w_lsu_addr    = o_lsu_write ? word_addr : '0;
    assign o_w_lsu_byte_en = o_lsu_write ? lane_be : 4'b0000;
    assign o_w_lsu_data    = o_lsu_write ? lane_wdata : '0;

endmodule

// File: tb/tb_core_lsu.sv
// Directed bench for core_lsu with a synchronous word RAM model
// answering the arbiter read/write ports.
module tb_core_lsu;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        misaligned;
    logic        lsu_read;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        lsu_write;
    logic [31:0] w_addr;
    logic [3:0]  w_be;
    logic [31:0] w_data;
    logic        mem_stall;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;
    int lat;

    core_lsu #(.AW(32), .DW(32)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_clk_en        (clk_en),
        .i_req_valid     (req_valid),
        .i_req_store     (req_store),
        .i_req_funct3    (req_funct3),
        .i_req_addr      (req_addr),
        .i_req_wdata     (req_wdata),
        .o_req_ready     (req_ready),
        .o_resp_valid    (resp_valid),
        .o_resp_data     (resp_data),
        .o_misaligned    (misaligned),
        .o_lsu_read      (lsu_read),
        .o_r_lsu_addr    (r_addr),
        .i_r_lsu_data    (r_data),
        .o_lsu_write     (lsu_write),
        .o_w_lsu_addr    (w_addr),
        .o_w_lsu_byte_en (w_be),
        .o_w_lsu_data    (w_data),
        .i_mem_stall     (mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lsu_read && !mem_stall) r_data <= mem[r_addr[9:2]];
        if (lsu_write && !mem_stall) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) mem[w_addr[9:2]][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op during an IDLE cycle; returns one cycle after accept.
    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 1;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic load(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] exp);
        issue(1'b0, f3, a, 32'h0);
        wait_resp(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_data"}, resp_data, exp);
        chk({tag, "_mis"}, {31'b0, misaligned}, 32'd0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h80] = 32'h80FF7F01;
        r_data     = 32'h0;
        rst        = 1'b1;
        clk_en     = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_stall  = 1'b0;
        tick();
        tick();
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp", {31'b0, resp_valid}, 32'd0);
        chk("rst_rd", {31'b0, lsu_read}, 32'd0);
        chk("rst_wr", {31'b0, lsu_write}, 32'd0);
        chk("rst_be", {28'b0, w_be}, 32'd0);
        rst = 1'b0;
        tick();

        issue(1'b1, 3'b000, 32'h102, 32'h000000AB);
        chk("sb_wr", {31'b0, lsu_write}, 32'd1);
        chk("sb_rd", {31'b0, lsu_read}, 32'd0);
        chk("sb_addr", w_addr, 32'h100);
        chk("sb_be", {28'b0, w_be}, 32'h4);
        chk("sb_data", w_data, 32'hABABABAB);
        chk("sb_rdy", {31'b0, req_ready}, 32'd0);
        tick();
        chk("sb_resp", {31'b0, resp_valid}, 32'd1);
        chk("sb_rdata", resp_data, 32'h0);
        chk("sb_wr_off", {31'b0, lsu_write}, 32'd0);
        tick();
        chk("sb_idle", {31'b0, req_ready}, 32'd1);
        chk("sb_pulse", {31'b0, resp_valid}, 32'd0);
        chk("sb_mem", mem[8'h40], 32'h00AB0000);

        issue(1'b1, 3'b001, 32'h106, 32'h1234BEEF);
        chk("sh_be", {28'b0, w_be}, 32'hC);
        chk("sh_data", w_data, 32'hBEEFBEEF);
        chk("sh_addr", w_addr, 32'h104);
        tick();
        tick();
        issue(1'b1, 3'b010, 32'h108, 32'h12345678);
        chk("sw_be", {28'b0, w_be}, 32'hF);
        chk("sw_data", w_data, 32'h12345678);
        tick();
        tick();
        chk("sh_mem", mem[8'h41], 32'hBEEF0000);
        chk("sw_mem", mem[8'h42], 32'h12345678);

        load("lb", 3'b000, 32'h203, 32'hFFFFFF80);
        load("lbu", 3'b100, 32'h203, 32'h00000080);
        load("lh", 3'b001, 32'h202, 32'hFFFF80FF);
        load("lw", 3'b010, 32'h200, 32'h80FF7F01);
        load("lhu", 3'b101, 32'h200, 32'h00007F01);
        load("lb1", 3'b000, 32'h201, 32'h0000007F);

        mem_stall = 1'b1;
        issue(1'b0, 3'b010, 32'h200, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("stl_rd", {31'b0, lsu_read}, 32'd1);
            chk("stl_addr", r_addr, 32'h200);
            if (i == 4) mem_stall = 1'b0;
            tick();
        end
        chk("stl_rdata_rd", {31'b0, lsu_read}, 32'd0);
        chk("stl_no_resp", {31'b0, resp_valid}, 32'd0);
        tick();
        chk("stl_resp", {31'b0, resp_valid}, 32'd1);
        chk("stl_data", resp_data, 32'h80FF7F01);
        tick();

        issue(1'b0, 3'b010, 32'h201, 32'h0);
        chk("mlw_resp", {31'b0, resp_valid}, 32'd1);
        chk("mlw_mis", {31'b0, misaligned}, 32'd1);
        chk("mlw_rd", {31'b0, lsu_read}, 32'd0);
        chk("mlw_data", resp_data, 32'h0);
        tick();
        chk("mlw_clr", {31'b0, misaligned}, 32'd0);
        issue(1'b1, 3'b001, 32'h003, 32'h5555);
        chk("msh_resp", {31'b0, resp_valid}, 32'd1);
        chk("msh_mis", {31'b0, misaligned}, 32'd1);
        chk("msh_wr", {31'b0, lsu_write}, 32'd0);
        tick();

        issue(1'b0, 3'b000, 32'h203, 32'h0);
        tick();
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ce_rdy", {31'b0, req_ready}, 32'd0);
            chk("ce_resp", {31'b0, resp_valid}, 32'd0);
            chk("ce_rd", {31'b0, lsu_read}, 32'd0);
        end
        clk_en = 1'b1;
        tick();
        chk("ce_resp_on", {31'b0, resp_valid}, 32'd1);
        chk("ce_data", resp_data, 32'hFFFFFF80);
        clk_en = 1'b0;
        tick();
        chk("ce_hold", {31'b0, resp_valid}, 32'd1);
        clk_en = 1'b1;
        tick();
        chk("ce_done", {31'b0, resp_valid}, 32'd0);

        mem_stall = 1'b1;
        issue(1'b0, 3'b010, 32'h200, 32'h0);
        chk("rmo_rd", {31'b0, lsu_read}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmo_rd_off", {31'b0, lsu_read}, 32'd0);
        chk("rmo_rdy", {31'b0, req_ready}, 32'd1);
        chk("rmo_resp", {31'b0, resp_valid}, 32'd0);
        mem_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rmo_quiet", {31'b0, resp_valid}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
